qupls_tlb: RTL and testbench

Two-way set-associative, 128-set translation lookaside buffer that sits directly upstream of the hardware page-table walker. It translates 32-bit virtual addresses from the address-generation stage in a fixed two-cycle pipeline. On a miss it emits the miss request the walker enqueues. It accepts the walker's TLB write port to install completed translations.

---
 rtl/qupls_tlb_pkg.sv | 32 +++
 rtl/qupls_tlb_if.sv | 57 +++++
 rtl/qupls_tlb_way_ram.sv | 25 ++
 rtl/qupls_tlb.sv | 177 +++++++++++++++++
 tb/tb_qupls_tlb.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/qupls_tlb_pkg.sv
// Shared TLB types and constants: address/ASID/ROB index, PTE, TLB entry,
// invalidate-sweep states and the set geometry.
package qupls_tlb_pkg;

   localparam int TLB_SETS     = 128;
   localparam int TLB_IDX_BITS = 7;

   typedef logic [31:0] address_t;
   typedef logic [15:0] asid_t;
   typedef logic [5:0]  rob_ndx_t;

   typedef struct packed {
      logic        v;
      logic        g;
      logic [2:0]  rwx;
      logic [10:0] rsv;
      logic [15:0] ppn;
   } shpte_t;

   typedef struct packed {
      logic [8:0] vpn;
      asid_t      asid;
   } tlb_vpn_t;

   typedef struct packed {
      tlb_vpn_t vpn;
      shpte_t   pte;
   } tlb_entry_t;

   typedef enum logic {IDLE, SWEEP} tlb_inv_state_t;

endpackage

// File: rtl/qupls_tlb_if.sv
// TLB bus: lookup request/result, miss request to the walker, walker write
// port, invalidate control and miss statistics. slave = TLB, master = client.
interface qupls_tlb_if;
   import qupls_tlb_pkg::*;

   logic       req_v;
   logic       req_rdy;
   address_t   req_adr;
   asid_t      req_asid;
   rob_ndx_t   req_id;
   logic [1:0] req_qn;

   logic       res_v;
   logic       res_hit;
   address_t   res_padr;
   shpte_t     res_pte;
   rob_ndx_t   res_id;

   logic       tlbmiss;
   address_t   tlb_missadr;
   asid_t      tlb_missasid;
   rob_ndx_t   tlb_missid;
   logic [1:0] tlb_missqn;
   logic       in_que;

   logic       tlb_wr;
   logic       tlb_way;
   logic [TLB_IDX_BITS-1:0] tlb_entryno;
   tlb_entry_t tlb_entry;

   logic       inv_all;
   logic       inv_busy;
   logic [31:0] miss_cnt;

   modport slave (
      input  req_v, req_adr, req_asid, req_id, req_qn,
      output req_rdy,
      output res_v, res_hit, res_padr, res_pte, res_id,
      output tlbmiss, tlb_missadr, tlb_missasid, tlb_missid, tlb_missqn,
      input  in_que,
      input  tlb_wr, tlb_way, tlb_entryno, tlb_entry,
      input  inv_all,
      output inv_busy, miss_cnt
   );

   modport master (
      output req_v, req_adr, req_asid, req_id, req_qn,
      input  req_rdy,
      input  res_v, res_hit, res_padr, res_pte, res_id,
      input  tlbmiss, tlb_missadr, tlb_missasid, tlb_missid, tlb_missqn,
      output in_que,
      output tlb_wr, tlb_way, tlb_entryno, tlb_entry,
      output inv_all,
      input  inv_busy, miss_cnt
   );

endinterface

// File: rtl/qupls_tlb_way_ram.sv
// One TLB way: DEPTH-entry, 1 read / 1 write RAM with registered read.
// Ports: clk, we/waddr/wdata write port, raddr read address, rdata (next cycle).
module qupls_tlb_way_ram
   import qupls_tlb_pkg::*;
#(
   parameter int DEPTH = TLB_SETS,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  tlb_entry_t    wdata,
   input  logic [AW-1:0] raddr,
   output tlb_entry_t    rdata
);

   tlb_entry_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/qupls_tlb.sv
// Two-way set-associative TLB with a two-cycle lookup pipeline, walker write
// port with same-cycle bypass, and a one-set-per-cycle invalidate sweep.
// Ports: clk, rst (async, active-high), bus (qupls_tlb_if.slave).
// Option: QUPLS_TLB_GLOBAL_EN lets entries with pte.g match any ASID.
module qupls_tlb
   import qupls_tlb_pkg::*;
#(
   parameter int SETS = TLB_SETS,
   parameter int WAYS = 2
) (
   input logic        clk,
   input logic        rst,
   qupls_tlb_if.slave bus
);

   localparam int IW = $clog2(SETS);

   tlb_inv_state_t state, state_nxt;
   logic [IW-1:0]  inv_ctr, inv_ctr_nxt;
   logic           clr;

   logic [SETS-1:0] vld [WAYS];
   tlb_entry_t      rdat [WAYS];
   tlb_entry_t      ent [WAYS];
   logic [WAYS-1:0] byp, hit;
   logic [WAYS-1:0] s2_vld, s2_byp;
   tlb_entry_t      byp_ent;

   logic       s2_v;
   address_t   s2_adr;
   asid_t      s2_asid;
   rob_ndx_t   s2_id;
   logic [1:0] s2_qn;

   logic          accept;
   logic [IW-1:0] ridx, widx;

   assign ridx   = bus.req_adr[16 +: IW];
   assign widx   = bus.tlb_entryno[IW-1:0];
   assign accept = bus.req_v && bus.req_rdy;

   assign bus.req_rdy  = (state == IDLE);
   assign bus.inv_busy = (state == SWEEP);

   function automatic logic tag_hit(tlb_entry_t e, address_t a, asid_t s);
`ifdef QUPLS_TLB_GLOBAL_EN
      return e.pte.v && e.vpn.vpn == a[31:23] &&
             (e.vpn.asid == s || e.pte.g);
`else
      return e.pte.v && e.vpn.vpn == a[31:23] && e.vpn.asid == s;
`endif
   endfunction

   for (genvar w = 0; w < WAYS; w++) begin : g_way
      qupls_tlb_way_ram #(.DEPTH(SETS)) u_ram (
         .clk   (clk),
         .we    (bus.tlb_wr && bus.tlb_way == 1'(w)),
         .waddr (widx),
         .wdata (bus.tlb_entry),
         .raddr (ridx),
         .rdata (rdat[w])
      );
      // A write landing on the set being read this cycle must be seen
      // by stage 2; the RAM still returns the old contents.
      assign byp[w] = bus.tlb_wr && bus.tlb_way == 1'(w) && widx == ridx;
      assign ent[w] = s2_byp[w] ? byp_ent : rdat[w];
      assign hit[w] = s2_vld[w] && tag_hit(ent[w], s2_adr, s2_asid);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         inv_ctr <= '0;
      end else begin
         state   <= state_nxt;
         inv_ctr <= inv_ctr_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      inv_ctr_nxt = inv_ctr;
      clr         = 1'b0;
      unique case (state)
         IDLE: if (bus.inv_all) begin
            state_nxt   = SWEEP;
            inv_ctr_nxt = '0;
         end
         SWEEP: begin
            clr         = 1'b1;
            inv_ctr_nxt = inv_ctr + IW'(1);
            if (inv_ctr == IW'(SETS - 1))
               state_nxt = IDLE;
         end
      endcase
   end

   // Write is applied after the sweep clear so it wins on the same set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int w = 0; w < WAYS; w++)
            vld[w] <= '0;
      end else begin
         if (clr)
            for (int w = 0; w < WAYS; w++)
               vld[w][inv_ctr] <= 1'b0;
         if (bus.tlb_wr)
            vld[bus.tlb_way][widx] <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_v    <= 1'b0;
         s2_adr  <= '0;
         s2_asid <= '0;
         s2_id   <= '0;
         s2_qn   <= '0;
         s2_vld  <= '0;
         s2_byp  <= '0;
         byp_ent <= '0;
      end else begin
         s2_v <= accept;
         if (accept) begin
            s2_adr  <= bus.req_adr;
            s2_asid <= bus.req_asid;
            s2_id   <= bus.req_id;
            s2_qn   <= bus.req_qn;
            s2_byp  <= byp;
            byp_ent <= bus.tlb_entry;
            for (int w = 0; w < WAYS; w++)
               s2_vld[w] <= vld[w][ridx] | byp[w];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.res_v        <= 1'b0;
         bus.res_hit      <= 1'b0;
         bus.res_padr     <= '0;
         bus.res_pte      <= '0;
         bus.res_id       <= '0;
         bus.tlbmiss      <= 1'b0;
         bus.tlb_missadr  <= '0;
         bus.tlb_missasid <= '0;
         bus.tlb_missid   <= '0;
         bus.tlb_missqn   <= '0;
         bus.miss_cnt     <= '0;
      end else begin
         bus.res_v   <= s2_v;
         bus.res_hit <= s2_v && |hit;
         bus.tlbmiss <= s2_v && !(|hit);
         if (s2_v) begin
            bus.res_id   <= s2_id;
            bus.res_padr <= '0;
            bus.res_pte  <= '0;
            if (hit[0]) begin
               bus.res_padr <= {ent[0].pte.ppn, s2_adr[15:0]};
               bus.res_pte  <= ent[0].pte;
            end else if (hit[1]) begin
               bus.res_padr <= {ent[1].pte.ppn, s2_adr[15:0]};
               bus.res_pte  <= ent[1].pte;
            end
            if (!(|hit)) begin
               bus.tlb_missadr  <= s2_adr;
               bus.tlb_missasid <= s2_asid;
               bus.tlb_missid   <= s2_id;
               bus.tlb_missqn   <= s2_qn;
               if (!bus.in_que)
                  bus.miss_cnt <= bus.miss_cnt + 32'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_qupls_tlb.sv
// Directed self-checking bench for qupls_tlb: miss/hit, bypass, way priority,
// ASID/global match, in_que statistics, invalidate sweep and reset abort.
module tb_qupls_tlb;
   import qupls_tlb_pkg::*;

   logic clk;
   logic rst;
   int   checks;
   int   fails;
   int   n;
   logic [31:0] exp_mc;

   qupls_tlb_if bus();

   qupls_tlb dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic tlb_entry_t mk(input logic [8:0] vpn,
                                     input logic [15:0] asid,
                                     input logic [15:0] ppn,
                                     input logic g);
      tlb_entry_t e;
      e = '0;
      e.vpn.vpn  = vpn;
      e.vpn.asid = asid;
      e.pte.v    = 1'b1;
      e.pte.g    = g;
      e.pte.ppn  = ppn;
      return e;
   endfunction

   task automatic set_wr(input logic [6:0] idx, input logic way,
                         input tlb_entry_t e);
      bus.tlb_wr      = 1'b1;
      bus.tlb_entryno = idx;
      bus.tlb_way     = way;
      bus.tlb_entry   = e;
   endtask

   task automatic install(input logic [6:0] idx, input logic way,
                          input tlb_entry_t e);
      set_wr(idx, way, e);
      step();
      bus.tlb_wr = 1'b0;
   endtask

   task automatic lookup(input string tag, input logic [31:0] adr,
                         input logic [15:0] asid, input logic [5:0] id,
                         input logic [1:0] qn, input logic que,
                         input logic exp_hit, input logic [31:0] exp_padr);
      bus.req_adr  = adr;
      bus.req_asid = asid;
      bus.req_id   = id;
      bus.req_qn   = qn;
      bus.in_que   = que;
      bus.req_v    = 1'b1;
      step();
      bus.req_v  = 1'b0;
      bus.tlb_wr = 1'b0;
      step();
      if (!exp_hit && !que)
         exp_mc = exp_mc + 32'd1;
      chk({tag, "_res_v"}, 64'(bus.res_v), 64'd1);
      chk({tag, "_hit"}, 64'(bus.res_hit), 64'(exp_hit));
      chk({tag, "_tlbmiss"}, 64'(bus.tlbmiss), 64'(!exp_hit));
      chk({tag, "_padr"}, 64'(bus.res_padr), 64'(exp_padr));
      chk({tag, "_id"}, 64'(bus.res_id), 64'(id));
      chk({tag, "_misscnt"}, 64'(bus.miss_cnt), 64'(exp_mc));
      if (exp_hit) begin
         chk({tag, "_pte_v"}, 64'(bus.res_pte.v), 64'd1);
      end else begin
         chk({tag, "_pte0"}, 64'(bus.res_pte), 64'd0);
         chk({tag, "_madr"}, 64'(bus.tlb_missadr), 64'(adr));
         chk({tag, "_masid"}, 64'(bus.tlb_missasid), 64'(asid));
         chk({tag, "_mid"}, 64'(bus.tlb_missid), 64'(id));
         chk({tag, "_mqn"}, 64'(bus.tlb_missqn), 64'(qn));
      end
      bus.in_que = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0;
      fails  = 0;
      exp_mc = '0;
      rst    = 1'b1;
      bus.req_v       = 1'b0;
      bus.req_adr     = '0;
      bus.req_asid    = '0;
      bus.req_id      = '0;
      bus.req_qn      = '0;
      bus.in_que      = 1'b0;
      bus.tlb_wr      = 1'b0;
      bus.tlb_way     = 1'b0;
      bus.tlb_entryno = '0;
      bus.tlb_entry   = '0;
      bus.inv_all     = 1'b0;
      repeat (3) step();

      chk("rst_req_rdy", 64'(bus.req_rdy), 64'd1);
      chk("rst_inv_busy", 64'(bus.inv_busy), 64'd0);
      chk("rst_miss_cnt", 64'(bus.miss_cnt), 64'd0);
      chk("rst_res_v", 64'(bus.res_v), 64'd0);
      chk("rst_res_hit", 64'(bus.res_hit), 64'd0);
      chk("rst_res_padr", 64'(bus.res_padr), 64'd0);
      chk("rst_tlbmiss", 64'(bus.tlbmiss), 64'd0);
      chk("rst_missadr", 64'(bus.tlb_missadr), 64'd0);
      rst = 1'b0;
      step();

      lookup("cold", 32'h0012_3456, 16'd5, 6'd3, 2'd1, 1'b0, 1'b0, 32'h0);
      step();
      chk("miss_not_held", 64'(bus.tlbmiss), 64'd0);
      chk("res_v_pulse", 64'(bus.res_v), 64'd0);

      install(7'h12, 1'b1, mk(9'h000, 16'd5, 16'hABCD, 1'b0));
      lookup("w1hit", 32'h0012_3456, 16'd5, 6'd4, 2'd0, 1'b0,
             1'b1, 32'hABCD_3456);

      set_wr(7'h34, 1'b0, mk(9'h001, 16'd5, 16'h5555, 1'b0));
      lookup("byp_new", 32'h00B4_0010, 16'd5, 6'd5, 2'd2, 1'b0,
             1'b1, 32'h5555_0010);

      set_wr(7'h12, 1'b0, mk(9'h000, 16'd5, 16'hABCD, 1'b0));
      lookup("byp_12", 32'h0012_0010, 16'd5, 6'd6, 2'd0, 1'b0,
             1'b1, 32'hABCD_0010);

      install(7'h12, 1'b0, mk(9'h000, 16'd5, 16'h7777, 1'b0));
      lookup("way0_wins", 32'h0012_3456, 16'd5, 6'd7, 2'd0, 1'b0,
             1'b1, 32'h7777_3456);

      lookup("asid6", 32'h0012_3456, 16'd6, 6'd8, 2'd3, 1'b0, 1'b0, 32'h0);

      install(7'h56, 1'b1, mk(9'h000, 16'd5, 16'h4444, 1'b1));
`ifdef QUPLS_TLB_GLOBAL_EN
      lookup("global", 32'h0056_0020, 16'd6, 6'd9, 2'd0, 1'b0,
             1'b1, 32'h4444_0020);
`else
      lookup("global", 32'h0056_0020, 16'd6, 6'd9, 2'd0, 1'b0,
             1'b0, 32'h0);
`endif

      lookup("in_que", 32'h0012_3456, 16'd9, 6'd10, 2'd1, 1'b1,
             1'b0, 32'h0);

      bus.req_adr  = 32'h0012_3456;
      bus.req_asid = 16'd5;
      bus.req_id   = 6'd11;
      bus.req_v    = 1'b1;
      step();
      bus.req_asid = 16'd7;
      bus.req_id   = 6'd12;
      step();
      bus.req_v = 1'b0;
      chk("b2b_hit", 64'(bus.res_hit), 64'd1);
      chk("b2b_padr", 64'(bus.res_padr), 64'h7777_3456);
      chk("b2b_id0", 64'(bus.res_id), 64'd11);
      step();
      exp_mc = exp_mc + 32'd1;
      chk("b2b_miss", 64'(bus.tlbmiss), 64'd1);
      chk("b2b_id1", 64'(bus.res_id), 64'd12);
      chk("b2b_cnt", 64'(bus.miss_cnt), 64'(exp_mc));
      step();

      bus.inv_all = 1'b1;
      step();
      bus.inv_all = 1'b0;
      chk("sweep_busy", 64'(bus.inv_busy), 64'd1);
      chk("sweep_rdy", 64'(bus.req_rdy), 64'd0);
      n = 0;
      while (bus.req_rdy == 1'b0 && n < 300) begin
         bus.tlb_wr  = 1'b0;
         bus.inv_all = (n == 50);
         if (n == 100) set_wr(7'h02, 1'b0, mk(9'h000, 16'd5, 16'h2222, 1'b0));
         if (n == 101) set_wr(7'h70, 1'b0, mk(9'h000, 16'd5, 16'h6666, 1'b0));
         if (n == 120) set_wr(7'h78, 1'b1, mk(9'h000, 16'd5, 16'h3333, 1'b0));
         step();
         n++;
      end
      bus.tlb_wr  = 1'b0;
      bus.inv_all = 1'b0;
      chk("sweep_len", 64'(n), 64'd128);
      chk("sweep_done", 64'(bus.inv_busy), 64'd0);

      lookup("inv_old", 32'h0012_3456, 16'd5, 6'd13, 2'd0, 1'b0,
             1'b0, 32'h0);
      lookup("inv_swept_wr", 32'h0002_0000, 16'd5, 6'd14, 2'd0, 1'b0,
             1'b1, 32'h2222_0000);
      lookup("inv_later_clr", 32'h0070_0000, 16'd5, 6'd15, 2'd0, 1'b0,
             1'b0, 32'h0);
      lookup("inv_same_set", 32'h0078_0000, 16'd5, 6'd16, 2'd0, 1'b0,
             1'b1, 32'h3333_0000);

      bus.req_adr  = 32'h0002_0000;
      bus.req_asid = 16'd5;
      bus.req_v    = 1'b1;
      step();
      bus.req_v = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      exp_mc = '0;
      chk("abort_res_v", 64'(bus.res_v), 64'd0);
      chk("abort_tlbmiss", 64'(bus.tlbmiss), 64'd0);
      chk("abort_cnt", 64'(bus.miss_cnt), 64'd0);
      chk("abort_rdy", 64'(bus.req_rdy), 64'd1);
      lookup("post_rst", 32'h0002_0000, 16'd5, 6'd17, 2'd0, 1'b0,
             1'b0, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
